cam_cfg_sequencer: RTL and testbench
====================================

CAM_CFG_SEQUENCER -- requirements
Module: cam_cfg_sequencer

Interface
REQ-001 Parameters SHALL be:
  RST_CYCLES, 1000, camera hard-reset hold length in clk cycles.
  PWRUP_CYCLES, 100000, wait after camera reset release in clk cycles.
  MS_CYCLES, 100000, clk cycles per delay unit.
  TIMEOUT_CYCLES, 1000000, maximum wait for mst_done.
REQ-002 Ports SHALL be:
  clk  in  1  system clock
  reset  in  1  synchronous, active-high
  start  in  1  pulse; begin or re-run the configuration sequence
  rom_addr  out  8  configuration ROM address
  rom_data  in  16  ROM word {reg_addr, reg_data}; valid 1 cycle after rom_addr
  user_req  in  1  runtime register write request, level
  user_addr  in  8  runtime register address
  user_data  in  8  runtime register data
  user_ack  out  1  1-cycle pulse; user write completed
  mst_start  out  1  1-cycle pulse to the SCCB write master
  mst_reg_addr  out  8  register address to the master
  mst_reg_data  out  8  register data to the master
  mst_busy  in  1  master transaction in progress
  mst_done  in  1  1-cycle pulse; master transaction finished
  cam_rst_n  out  1  camera RESET pin, active-low
  cam_pwdn  out  1  camera PWDN pin, active-high
  cfg_done  out  1  configuration sequence complete
  err  out  1  sticky; a transaction timed out
  wr_count  out  8  ROM writes issued in the current sequence

Function
REQ-003 States SHALL be IDLE, CAM_RST, PWRUP, FETCH, DECODE, ISSUE, WAIT, DELAY, READY, U_ISSUE, U_WAIT.
REQ-004 IDLE: cam_pwdn=1, cam_rst_n=1; start -> CAM_RST, clear rom_addr, wr_count, cfg_done.
REQ-005 CAM_RST: cam_pwdn=0, cam_rst_n=0 for exactly RST_CYCLES, then -> PWRUP with cam_rst_n=1.
REQ-006 PWRUP: wait PWRUP_CYCLES, then -> FETCH.
REQ-007 FETCH: drive rom_addr for one cycle -> DECODE; DECODE samples rom_data.
REQ-008 DECODE: 16'hFFFF -> READY, cfg_done=1; 8'hF0 upper byte -> DELAY for (lower byte x MS_CYCLES) cycles, where lower byte 0 means zero wait; otherwise -> ISSUE.
REQ-009 ISSUE: wait for mst_busy=0, pulse mst_start for one cycle, latch mst_reg_addr/mst_reg_data, increment wr_count, -> WAIT.
REQ-010 mst_reg_addr/mst_reg_data SHALL hold stable from the mst_start pulse until the cycle after mst_done.
REQ-011 WAIT: mst_done -> advance; a count of TIMEOUT_CYCLES without mst_done -> set err and advance, skipping the entry.
REQ-012 After DELAY or WAIT completes: if rom_addr==8'hFF -> READY, cfg_done=1 (implicit end); else rom_addr+1 -> FETCH.
REQ-013 wr_count SHALL saturate at 8'hFF.
REQ-014 user_ack SHALL remain 0 until cfg_done=1; user_req is held off, not dropped.
REQ-015 READY: start -> CAM_RST, which clears cfg_done; otherwise user_req -> U_ISSUE. If start and user_req are asserted in the same cycle, start wins and user_req stays pending.
REQ-016 U_ISSUE/U_WAIT SHALL follow REQ-009..REQ-011 using user_addr/user_data captured at entry and without changing wr_count; on completion or timeout, pulse user_ack once -> READY.
REQ-017 start SHALL be ignored in all states except IDLE and READY.
REQ-018 Only one transaction SHALL be outstanding; mst_start SHALL never pulse while in WAIT or U_WAIT.
REQ-019 mst_done outside WAIT/U_WAIT SHALL be ignored.

Reset
REQ-020 reset SHALL take priority over all inputs and force IDLE; rom_addr=0, mst_start=0, mst_reg_addr=0, mst_reg_data=0, user_ack=0, cam_rst_n=1, cam_pwdn=1, cfg_done=0, err=0, wr_count=0, all timers=0.
REQ-021 reset mid-transaction SHALL abandon the sequence with no further mst_start pulse; mst_done after reset SHALL be ignored.

Verification
REQ-022 ROM {1280, 1100, FFFF}, master responds with mst_done 10 cycles after mst_start -> cam_rst_n low for RST_CYCLES, two mst_start pulses (12/80 then 11/00), cfg_done=1, wr_count=2, err=0.
REQ-023 ROM {F005, 3A04, FFFF} -> gap from DECODE of F005 to mst_start of 3A04 = 5 x MS_CYCLES (+/-3 cycles); wr_count=1.
REQ-024 user_req with 40/C0 raised during the sequence -> no user_ack before cfg_done; exactly one mst_start with 40/C0 afterwards, then one user_ack pulse.
REQ-025 Master never asserts mst_done -> err=1 after TIMEOUT_CYCLES, next entry issued, sequence still reaches cfg_done.
REQ-026 reset while in WAIT -> all REQ-020 values next cycle; no mst_start until a new start; ROM without FFFF -> sequence ends after address FF with wr_count=FF.
REQ-027 start and user_req asserted together in READY -> sequence re-runs, cfg_done=0; user write served after the new cfg_done.

Source files
------------

// File: rtl/cam_cfg_sequencer.sv
// Camera bring-up sequencer: power/reset pin sequencing, ROM-driven register
// configuration through an SCCB write master, then runtime register writes.
module cam_cfg_sequencer #(
   parameter int RST_CYCLES     = 1000,
   parameter int PWRUP_CYCLES   = 100000,
   parameter int MS_CYCLES      = 100000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   input  logic        user_req,
   input  logic [7:0]  user_addr,
   input  logic [7:0]  user_data,
   output logic        user_ack,
   output logic        mst_start,
   output logic [7:0]  mst_reg_addr,
   output logic [7:0]  mst_reg_data,
   input  logic        mst_busy,
   input  logic        mst_done,
   output logic        cam_rst_n,
   output logic        cam_pwdn,
   output logic        cfg_done,
   output logic        err,
   output logic [7:0]  wr_count
);
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CAM_RST = 4'd1,
      PWRUP   = 4'd2,
      FETCH   = 4'd3,
      DECODE  = 4'd4,
      ISSUE   = 4'd5,
      WAIT    = 4'd6,
      DELAY   = 4'd7,
      READY   = 4'd8,
      U_ISSUE = 4'd9,
      U_WAIT  = 4'd10
   } state_t;

   localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
   localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYCLES - 1);
   localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] MS_LEN     = 32'(MS_CYCLES);
   // FETCH/DECODE/ISSUE after a delay already cost cycles; end the delay early by that much.
   localparam logic [31:0] DELAY_TRIM = 32'd4;

   state_t      state_r, state_s;
   logic [7:0]  rom_addr_r, rom_addr_s;
   logic [15:0] rom_word_r, rom_word_s;
   logic [7:0]  user_addr_r, user_addr_s;
   logic [7:0]  user_data_r, user_data_s;
   logic        mst_start_r, mst_start_s;
   logic [7:0]  mst_reg_addr_r, mst_reg_addr_s;
   logic [7:0]  mst_reg_data_r, mst_reg_data_s;
   logic        user_ack_r, user_ack_s;
   logic        cam_rst_n_r, cam_rst_n_s;
   logic        cam_pwdn_r, cam_pwdn_s;
   logic        cfg_done_r, cfg_done_s;
   logic        err_r, err_s;
   logic [7:0]  wr_count_r, wr_count_s;
   logic [31:0] timer_r, timer_s;
   logic        last_entry_s;

   assign last_entry_s = (rom_addr_r == 8'hFF);

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_s        = state_r;
      rom_addr_s     = rom_addr_r;
      rom_word_s     = rom_word_r;
      user_addr_s    = user_addr_r;
      user_data_s    = user_data_r;
      mst_start_s    = 1'b0;
      mst_reg_addr_s = mst_reg_addr_r;
      mst_reg_data_s = mst_reg_data_r;
      user_ack_s     = 1'b0;
      cam_rst_n_s    = cam_rst_n_r;
      cam_pwdn_s     = cam_pwdn_r;
      cfg_done_s     = cfg_done_r;
      err_s          = err_r;
      wr_count_s     = wr_count_r;
      timer_s        = timer_r;
      case (state_r)
         IDLE: begin
            cam_pwdn_s  = 1'b1;
            cam_rst_n_s = 1'b1;
            if (start) begin
               state_s     = CAM_RST;
               rom_addr_s  = 8'd0;
               wr_count_s  = 8'd0;
               cfg_done_s  = 1'b0;
               cam_pwdn_s  = 1'b0;
               cam_rst_n_s = 1'b0;
               timer_s     = 32'd0;
            end else begin
               state_s = IDLE;
            end
         end
         CAM_RST: begin
            if (timer_r == RST_LAST) begin
               state_s     = PWRUP;
               cam_rst_n_s = 1'b1;
               timer_s     = 32'd0;
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         PWRUP: begin
            if (timer_r == PWRUP_LAST) begin
               state_s = FETCH;
               timer_s = 32'd0;
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         FETCH: begin
            state_s = DECODE;
         end
         DECODE: begin
            if (rom_data == 16'hFFFF) begin
               state_s    = READY;
               cfg_done_s = 1'b1;
            end else if (rom_data[15:8] == 8'hF0) begin
               state_s = DELAY;
               timer_s = {24'd0, rom_data[7:0]} * MS_LEN;
            end else begin
               state_s    = ISSUE;
               rom_word_s = rom_data;
            end
         end
         ISSUE: begin
            if (!mst_busy) begin
               state_s        = WAIT;
               mst_start_s    = 1'b1;
               mst_reg_addr_s = rom_word_r[15:8];
               mst_reg_data_s = rom_word_r[7:0];
               wr_count_s     = (wr_count_r == 8'hFF) ? 8'hFF : wr_count_r + 8'd1;
               timer_s        = 32'd0;
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT: begin
            if (mst_done || (timer_r == TO_LAST)) begin
               err_s      = err_r | ~mst_done;
               state_s    = last_entry_s ? READY : FETCH;
               cfg_done_s = last_entry_s;
               rom_addr_s = last_entry_s ? rom_addr_r : rom_addr_r + 8'd1;
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         DELAY: begin
            if (timer_r <= DELAY_TRIM) begin
               state_s    = last_entry_s ? READY : FETCH;
               cfg_done_s = last_entry_s;
               rom_addr_s = last_entry_s ? rom_addr_r : rom_addr_r + 8'd1;
            end else begin
               timer_s = timer_r - 32'd1;
            end
         end
         READY: begin
            // The ack cycle masks user_req so a level request is not re-served before it drops.
            if (start) begin
               state_s     = CAM_RST;
               rom_addr_s  = 8'd0;
               wr_count_s  = 8'd0;
               cfg_done_s  = 1'b0;
               cam_pwdn_s  = 1'b0;
               cam_rst_n_s = 1'b0;
               timer_s     = 32'd0;
            end else if (user_req && !user_ack_r) begin
               state_s     = U_ISSUE;
               user_addr_s = user_addr;
               user_data_s = user_data;
            end else begin
               state_s = READY;
            end
         end
         U_ISSUE: begin
            if (!mst_busy) begin
               state_s        = U_WAIT;
               mst_start_s    = 1'b1;
               mst_reg_addr_s = user_addr_r;
               mst_reg_data_s = user_data_r;
               timer_s        = 32'd0;
            end else begin
               state_s = U_ISSUE;
            end
         end
         U_WAIT: begin
            if (mst_done || (timer_r == TO_LAST)) begin
               err_s      = err_r | ~mst_done;
               state_s    = READY;
               user_ack_s = 1'b1;
            end else begin
               timer_s = timer_r + 32'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers; reset returns every output to its idle value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         rom_addr_r     <= 8'd0;
         rom_word_r     <= 16'd0;
         user_addr_r    <= 8'd0;
         user_data_r    <= 8'd0;
         mst_start_r    <= 1'b0;
         mst_reg_addr_r <= 8'd0;
         mst_reg_data_r <= 8'd0;
         user_ack_r     <= 1'b0;
         cam_rst_n_r    <= 1'b1;
         cam_pwdn_r     <= 1'b1;
         cfg_done_r     <= 1'b0;
         err_r          <= 1'b0;
         wr_count_r     <= 8'd0;
         timer_r        <= 32'd0;
      end else begin
         state_r        <= state_s;
         rom_addr_r     <= rom_addr_s;
         rom_word_r     <= rom_word_s;
         user_addr_r    <= user_addr_s;
         user_data_r    <= user_data_s;
         mst_start_r    <= mst_start_s;
         mst_reg_addr_r <= mst_reg_addr_s;
         mst_reg_data_r <= mst_reg_data_s;
         user_ack_r     <= user_ack_s;
         cam_rst_n_r    <= cam_rst_n_s;
         cam_pwdn_r     <= cam_pwdn_s;
         cfg_done_r     <= cfg_done_s;
         err_r          <= err_s;
         wr_count_r     <= wr_count_s;
         timer_r        <= timer_s;
      end
   end

   assign rom_addr     = rom_addr_r;
   assign mst_start    = mst_start_r;
   assign mst_reg_addr = mst_reg_addr_r;
   assign mst_reg_data = mst_reg_data_r;
   assign user_ack     = user_ack_r;
   assign cam_rst_n    = cam_rst_n_r;
   assign cam_pwdn     = cam_pwdn_r;
   assign cfg_done     = cfg_done_r;
   assign err          = err_r;
   assign wr_count     = wr_count_r;
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: table vectors, directed corner sequences and random
// ROM images checked against a ROM-walk reference model and a latency-driven master.
`timescale 1ns/1ps
module tb_cam_cfg_sequencer;
   localparam int RST_C = 10;
   localparam int PWR_C = 20;
   localparam int MS_C  = 16;
   localparam int TO_C  = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data = 16'h0000;
   logic        user_req = 1'b0;
   logic [7:0]  user_addr = 8'h00;
   logic [7:0]  user_data = 8'h00;
   logic        user_ack;
   logic        mst_start;
   logic [7:0]  mst_reg_addr;
   logic [7:0]  mst_reg_data;
   logic        mst_busy = 1'b0;
   logic        mst_done = 1'b0;
   logic        cam_rst_n;
   logic        cam_pwdn;
   logic        cfg_done;
   logic        err;
   logic [7:0]  wr_count;

   cam_cfg_sequencer #(
      .RST_CYCLES(RST_C), .PWRUP_CYCLES(PWR_C), .MS_CYCLES(MS_C), .TIMEOUT_CYCLES(TO_C)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .user_req(user_req), .user_addr(user_addr), .user_data(user_data), .user_ack(user_ack),
      .mst_start(mst_start), .mst_reg_addr(mst_reg_addr), .mst_reg_data(mst_reg_data),
      .mst_busy(mst_busy), .mst_done(mst_done), .cam_rst_n(cam_rst_n), .cam_pwdn(cam_pwdn),
      .cfg_done(cfg_done), .err(err), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, one cycle of read latency.
   logic [15:0] rom_mem [256];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // SCCB master model: logs each write and answers m_lat cycles later (or never).
   logic [15:0] log_q[$];
   int m_lat = 10;
   bit m_never = 1'b0;
   int m_cnt = 0;
   always @(posedge clk) begin
      mst_done <= 1'b0;
      if (mst_start === 1'b1) begin
         log_q.push_back({mst_reg_addr, mst_reg_data});
         mst_busy <= !m_never;
         m_cnt    <= m_lat;
      end else if (mst_busy && m_cnt <= 1) begin
         mst_busy <= 1'b0;
         mst_done <= 1'b1;
      end else if (mst_busy) begin
         m_cnt <= m_cnt - 1;
      end
   end

   // Output monitor sampled on the falling edge.
   int   cyc = 0, ack_cnt = 0, ack_bad = 0, rst_low = 0, rise_cyc = 0;
   int   start_cyc[$];
   logic prev_rst_n = 1'b1;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (user_ack === 1'b1) ack_cnt <= ack_cnt + 1;
      if (user_ack === 1'b1 && cfg_done !== 1'b1) ack_bad <= ack_bad + 1;
      if (cam_rst_n === 1'b0) rst_low <= rst_low + 1;
      if (cam_rst_n === 1'b1 && prev_rst_n === 1'b0) rise_cyc <= cyc;
      if (mst_start === 1'b1) start_cyc.push_back(cyc);
      prev_rst_n <= cam_rst_n;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (cfg_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ack(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (user_ack === 1'b1) begin
            user_req = 1'b0;
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [63:0] rst_view();
      return {26'd0, rom_addr, mst_start, mst_reg_addr, mst_reg_data, user_ack,
              cam_rst_n, cam_pwdn, cfg_done, err, wr_count};
   endfunction
   localparam logic [63:0] RST_EXP = {26'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0,
                                      1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

   typedef struct {
      logic [63:0] words;
      int          lat;
      bit          never;
      int          n_wr;
      logic [7:0]  wr;
      bit          e;
      logic [15:0] t0;
      logic [15:0] t1;
      bit          gap;
   } vec_t;

   vec_t        vt[5];
   logic [15:0] exp_q[$];
   bit          ok, exp_err;
   int          base, sbase, rl0, ack0, bad0, gap, n;
   logic [15:0] w;
   logic [7:0]  ua, ud;

   initial begin
      vt[0] = '{64'h1280_1100_FFFF_0000, 10, 1'b0, 2, 8'd2, 1'b0, 16'h1280, 16'h1100, 1'b0};
      vt[1] = '{64'hF005_3A04_FFFF_0000,  3, 1'b0, 1, 8'd1, 1'b0, 16'h3A04, 16'h0000, 1'b1};
      vt[2] = '{64'h1280_1100_FFFF_0000, 10, 1'b1, 2, 8'd2, 1'b1, 16'h1280, 16'h1100, 1'b0};
      vt[3] = '{64'hFFFF_1234_5678_0000,  3, 1'b0, 0, 8'd0, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vt[4] = '{64'hF000_5501_F001_FFFF,  1, 1'b0, 1, 8'd1, 1'b0, 16'h5501, 16'h0000, 1'b0};
      for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;

      tick(2);
      check("reset_state", rst_view(), RST_EXP);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;
         for (int k = 0; k < 4; k++) rom_mem[k] = vt[i].words[63 - 16 * k -: 16];
         m_lat = vt[i].lat;
         m_never = vt[i].never;
         do_reset();
         #1;
         base = log_q.size(); sbase = start_cyc.size(); rl0 = rst_low;
         pulse_start();
         wait_done(20000, ok);
         #1;
         check($sformatf("v%0d_cfg_done", i), ok, 1);
         check($sformatf("v%0d_n_writes", i), log_q.size() - base, vt[i].n_wr);
         check($sformatf("v%0d_wr_count", i), wr_count, vt[i].wr);
         check($sformatf("v%0d_err", i), err, vt[i].e);
         check($sformatf("v%0d_rst_low", i), rst_low - rl0, RST_C);
         if (vt[i].n_wr > 0 && log_q.size() > base)
            check($sformatf("v%0d_txn0", i), log_q[base], vt[i].t0);
         if (vt[i].n_wr > 1 && log_q.size() > base + 1)
            check($sformatf("v%0d_txn1", i), log_q[base + 1], vt[i].t1);
         if (vt[i].gap && start_cyc.size() > sbase) begin
            gap = start_cyc[sbase] - (rise_cyc + PWR_C + 1);
            check_range("delay_gap", gap, 5 * MS_C, 3);
         end
      end

      // User write raised mid-sequence is deferred until configuration completes.
      for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;
      rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1100;
      m_lat = 10; m_never = 1'b0;
      do_reset();
      #1;
      base = log_q.size(); ack0 = ack_cnt; bad0 = ack_bad;
      pulse_start();
      tick(3);
      user_req = 1'b1; user_addr = 8'h40; user_data = 8'hC0;
      wait_done(20000, ok);
      #1;
      check("ureq_cfg_done", ok, 1);
      check("ureq_no_early_ack", ack_cnt - ack0, 0);
      wait_ack(2000, ok);
      check("ureq_ack_seen", ok, 1);
      tick(5);
      #1;
      check("ureq_ack_count", ack_cnt - ack0, 1);
      check("ureq_ack_before_done", ack_bad - bad0, 0);
      check("ureq_n_writes", log_q.size() - base, 3);
      if (log_q.size() >= base + 3) check("ureq_txn", log_q[base + 2], 16'h40C0);
      check("ureq_wr_count", wr_count, 8'd2);

      // Reset while waiting on the master, then a full ROM with no terminator.
      for (int a = 0; a < 256; a++) rom_mem[a] = {8'h10, 8'(a)};
      do_reset();
      #1;
      base = log_q.size();
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (log_q.size() > base) begin ok = 1'b1; break; end
      end
      check("rstwait_first_start", ok, 1);
      tick(3);
      reset = 1'b1;
      tick(1);
      check("rstwait_state", rst_view(), RST_EXP);
      reset = 1'b0;
      base = log_q.size();
      tick(25);
      #1;
      check("rstwait_no_start", log_q.size() - base, 0);
      check("rstwait_idle_pwdn", cam_pwdn, 1);
      m_lat = 2;
      pulse_start();
      wait_done(20000, ok);
      #1;
      check("full_cfg_done", ok, 1);
      check("full_n_writes", log_q.size() - base, 256);
      check("full_wr_count", wr_count, 8'hFF);
      check("full_rom_addr", rom_addr, 8'hFF);
      check("full_err", err, 0);
      if (log_q.size() >= base + 256)
         for (int a = 0; a < 256; a++)
            check($sformatf("full_txn%0d", a), log_q[base + a], {8'h10, 8'(a)});

      // start and user_req together in READY: start wins, request served afterwards.
      rom_mem[0] = 16'hFFFF;
      base = log_q.size(); ack0 = ack_cnt;
      start = 1'b1; user_req = 1'b1; user_addr = 8'h77; user_data = 8'h33;
      tick(1);
      start = 1'b0;
      check("both_cfg_cleared", cfg_done, 0);
      check("both_cam_rst", cam_rst_n, 0);
      wait_done(20000, ok);
      #1;
      check("both_cfg_done", ok, 1);
      check("both_no_early_ack", ack_cnt - ack0, 0);
      check("both_wr_count", wr_count, 8'd0);
      wait_ack(2000, ok);
      check("both_ack_seen", ok, 1);
      tick(3);
      #1;
      check("both_n_writes", log_q.size() - base, 1);
      if (log_q.size() > base) check("both_txn", log_q[$], 16'h7733);

      // Random ROM images against the ROM-walk reference model.
      for (int it = 0; it < 20; it++) begin
         for (int a = 0; a < 256; a++) rom_mem[a] = 16'hFFFF;
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               w = {8'hF0, 8'($urandom_range(0, 2))};
            end else begin
               w = 16'($urandom);
               if (w[15:8] == 8'hF0) w[15:8] = 8'h3C;
            end
            rom_mem[k] = w;
         end
         m_lat = $urandom_range(1, 8);
         m_never = ($urandom_range(0, 4) == 0);
         exp_q.delete();
         for (int a = 0; a < 256; a++) begin
            if (rom_mem[a] == 16'hFFFF) break;
            if (rom_mem[a][15:8] != 8'hF0) exp_q.push_back(rom_mem[a]);
         end
         exp_err = m_never && (exp_q.size() > 0);
         do_reset();
         #1;
         base = log_q.size(); ack0 = ack_cnt;
         pulse_start();
         wait_done(20000, ok);
         #1;
         check($sformatf("r%0d_cfg_done", it), ok, 1);
         check($sformatf("r%0d_n_writes", it), log_q.size() - base, exp_q.size());
         check($sformatf("r%0d_wr_count", it), wr_count, exp_q.size());
         check($sformatf("r%0d_err", it), err, exp_err);
         if (log_q.size() == base + exp_q.size())
            for (int j = 0; j < exp_q.size(); j++)
               check($sformatf("r%0d_txn%0d", it, j), log_q[base + j], exp_q[j]);
         ua = 8'($urandom); ud = 8'($urandom);
         user_req = 1'b1; user_addr = ua; user_data = ud;
         wait_ack(2000, ok);
         tick(2);
         #1;
         check($sformatf("r%0d_user_ack", it), ack_cnt - ack0, 1);
         if (log_q.size() > base) check($sformatf("r%0d_user_txn", it), log_q[$], {ua, ud});
         check($sformatf("r%0d_user_err", it), err, exp_err | m_never);
         check($sformatf("r%0d_user_wr_count", it), wr_count, exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
